// File: rtl/pc_gen.sv
// Fetch-stage program counter: BOOT/RUN sequencer, branch/trap redirects and a one-entry pending-redirect buffer.
// Optional feature macro PC_MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being force-aligned.
module pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0020),
    parameter int                STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              imem_ready_i,
    input  logic              br_valid_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              trap_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              misalign_o,
    output logic              fsm_state
);

    // Fetch handshake: a fetch at pc is accepted on an edge where ce=1 and
    // imem_ready_i=1; only then (and without stall) does pc advance. Redirects
    // and traps do not wait for imem_ready_i and abort the in-flight fetch.

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_W     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

    state_t            state;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] redir_raw;
    logic [ADDR_W-1:0] redir_pc;
    logic              redir_misalign;

    // A live branch is younger than anything pending, so it wins.
    assign redir_raw = br_valid_i ? br_target_i : pend_target;

`ifdef PC_MISALIGN_TRAP_EN
    assign redir_misalign = |(redir_raw & ALIGN_MASK);
    assign redir_pc       = redir_misalign ? TRAP_VEC : redir_raw;
`else
    assign redir_misalign = 1'b0;
    assign redir_pc       = redir_raw & ~ALIGN_MASK;
`endif

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            pc          <= RESET_VEC;
            ce          <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            misalign_o  <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (state)
                BOOT: begin
                    ce    <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    ce <= 1'b1;
                    if (trap_i) begin
                        pc         <= TRAP_VEC;
                        pend_valid <= 1'b0;
                    end else if (br_valid_i && stall_i) begin
                        pend_valid  <= 1'b1;
                        pend_target <= br_target_i;
                    end else if (!stall_i && (br_valid_i || pend_valid)) begin
                        pc         <= redir_pc;
                        misalign_o <= redir_misalign;
                        pend_valid <= 1'b0;
                    end else if (imem_ready_i && !stall_i) begin
                        pc <= pc + STEP_W;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule
